// File: rtl/mem_data_access.sv
// MEM-stage data-side initiator: issues one SRAM-like bus access per memory
// instruction, stalls the pipeline until it completes and returns extended load data.
module mem_data_access #(
    parameter logic [31:0] RESET_ADDR = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_except,
    input  logic        mem_flush,
    input  logic        mem_advance,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        memory_stall,
    output logic [31:0] load_result,
    output logic        access_done
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        discard;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic        start;
    logic        complete;
    logic        drop;

    assign start    = mem_en & ~mem_except & ~mem_flush;
    assign complete = ((state == REQ) & data_addr_ok & data_data_ok) |
                      ((state == WAIT) & data_data_ok);
    // A flush that lands after the address was accepted cannot cancel the bus
    // transfer, so the completion is swallowed instead.
    assign drop     = discard | mem_flush;

    // NOTE: the stall is combinational so the pipeline releases on the data_ok cycle
    // itself; it is gated by rst because the FSM is forced to IDLE while a
    // memory instruction may still be presented.
    assign memory_stall = ~rst & (((state == IDLE) & start) |
                                  (((state == REQ) | (state == WAIT)) & ~complete));

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] r;
        // NOTE: blocking assignments inside functions and combinational code; a
        // default first keeps every path assigned.
        r = w;
        case (size)
            2'd0:    r = {4{w[7:0]}};
            2'd1:    r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lane,
                                            input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[7:0];
        unique case (lane)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (op[1:0])
            2'd0:    r = op[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    r = op[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the later completion block deliberately overrides the
    // state chosen by the case statement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            discard     <= 1'b0;
            op_q        <= 3'd0;
            lane_q      <= 2'd0;
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= 2'd0;
            data_addr   <= RESET_ADDR;
            data_wdata  <= 32'd0;
            load_result <= 32'd0;
            access_done <= 1'b0;
        end else begin
            access_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (start) begin
                        state      <= REQ;
                        data_req   <= 1'b1;
                        data_wr    <= mem_wr;
                        data_size  <= mem_op[1:0];
                        data_addr  <= mem_addr;
                        data_wdata <= replicate(mem_op[1:0], mem_wdata);
                        op_q       <= mem_op;
                        lane_q     <= mem_addr[1:0];
                    end else begin
                        data_addr  <= RESET_ADDR;
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (!data_data_ok) begin
                            state   <= WAIT;
                            discard <= mem_flush;
                        end
                    end else if (mem_flush) begin
                        data_req  <= 1'b0;
                        data_addr <= RESET_ADDR;
                        state     <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem_flush)
                        discard <= 1'b1;
                end
                DONE: begin
                    // Stay parked while a non-memory stall holds the register,
                    // so the same instruction is never issued twice.
                    if (mem_advance | mem_flush) begin
                        data_addr <= RESET_ADDR;
                        state     <= IDLE;
                    end
                end
            endcase

            if (complete) begin
                if (drop) begin
                    data_addr <= RESET_ADDR;
                    state     <= IDLE;
                end else begin
                    state       <= DONE;
                    access_done <= 1'b1;
                    load_result <= data_wr ? 32'd0 : extract(op_q, lane_q, data_rdata);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_data_access.sv
// Self-checking bench for mem_data_access: the bench plays the bus slave and
// predicts stall, handshake and load data from an arithmetic reference model.
module tb_mem_data_access;

    localparam logic [31:0] RESET_ADDR = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0, mem_wr = 1'b0, mem_except = 1'b0;
    logic        mem_flush = 1'b0, mem_advance = 1'b0;
    logic [2:0]  mem_op = 3'd0;
    logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    logic        memory_stall, access_done;
    logic [31:0] load_result;

    int tests = 0;
    int fails = 0;

    mem_data_access dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_except(mem_except), .mem_flush(mem_flush),
        .mem_advance(mem_advance),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .memory_stall(memory_stall), .load_result(load_result), .access_done(access_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: pick the naturally aligned field by arithmetic, then extend.
    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint unsigned bytes, off, span, v;
        bytes = 64'd1 << op[1:0];
        off   = (64'(addr[1:0]) / bytes) * bytes;
        span  = 64'd1 << (bytes * 8);
        v     = (64'(rdata) >> (off * 8)) % span;
        if (!op[2] && v >= span / 2)
            v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return (w & 32'h000000ff) * 32'h01010101;
        if (size == 2'd1) return (w & 32'h0000ffff) * 32'h00010001;
        return w;
    endfunction

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // One complete access: present instruction, answer as slave, hold in DONE, advance.
    task automatic do_access(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int addr_lat, input int data_lat, input int hold,
                             input string tag);
        logic [31:0] exp_r;
        int stall_bad, req_bad, field_bad, hold_bad;
        stall_bad = 0; req_bad = 0; field_bad = 0; hold_bad = 0;
        exp_r = wr ? 32'd0 : exp_load(op, addr, rdata);

        drive_edge();
        mem_en = 1'b1; mem_wr = wr; mem_op = op; mem_addr = addr; mem_wdata = wdata;
        mem_except = 1'b0; mem_flush = 1'b0; mem_advance = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        settle();
        tests++;
        if (memory_stall !== 1'b1 || data_req !== 1'b0) begin
            fails++;
            $display("FAIL %s start_cycle: stall=%b req=%b expected stall=1 req=0", tag, memory_stall, data_req);
        end

        for (int i = 0; i <= addr_lat; i++) begin
            drive_edge();
            data_addr_ok = (i == addr_lat);
            data_data_ok = (i == addr_lat) && (data_lat == 0);
            data_rdata   = data_data_ok ? rdata : $urandom;
            settle();
            if (data_req !== 1'b1) req_bad++;
            if (memory_stall !== !data_data_ok) stall_bad++;
            if (data_wr !== wr || data_size !== op[1:0] || data_addr !== addr ||
                (wr && data_wdata !== exp_wdata(op[1:0], wdata))) field_bad++;
        end
        for (int i = 1; i <= data_lat; i++) begin
            drive_edge();
            data_addr_ok = 1'b0;
            data_data_ok = (i == data_lat);
            data_rdata   = data_data_ok ? rdata : $urandom;
            settle();
            if (data_req !== 1'b0) req_bad++;
            if (memory_stall !== !data_data_ok) stall_bad++;
        end
        tests++;
        if (field_bad != 0) begin
            fails++;
            $display("FAIL %s req_fields: wr=%b size=%0d addr=%h wdata=%h expected wr=%b size=%0d addr=%h wdata=%h",
                     tag, data_wr, data_size, data_addr, data_wdata, wr, op[1:0], addr, exp_wdata(op[1:0], wdata));
        end
        tests++;
        if (stall_bad != 0 || req_bad != 0) begin
            fails++;
            $display("FAIL %s handshake: %0d stall errors, %0d req errors, expected 0 and 0", tag, stall_bad, req_bad);
        end

        drive_edge();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        settle();
        tests++;
        if (access_done !== 1'b1 || load_result !== exp_r || memory_stall !== 1'b0 || data_req !== 1'b0) begin
            fails++;
            $display("FAIL %s completion: done=%b result=%h stall=%b req=%b expected done=1 result=%h stall=0 req=0",
                     tag, access_done, load_result, memory_stall, data_req, exp_r);
        end

        for (int i = 0; i < hold; i++) begin
            drive_edge();
            data_data_ok = 1'($urandom_range(0, 1));
            data_rdata   = $urandom;
            settle();
            if (access_done !== 1'b0 || data_req !== 1'b0 || memory_stall !== 1'b0 ||
                load_result !== exp_r) hold_bad++;
        end
        tests++;
        if (hold_bad != 0) begin
            fails++;
            $display("FAIL %s done_hold: %0d bad cycles expected 0", tag, hold_bad);
        end

        drive_edge();
        data_data_ok = 1'b0; mem_advance = 1'b1;
        drive_edge();
        mem_advance = 1'b0; mem_en = 1'b0;
        settle();
        tests++;
        if (data_addr !== RESET_ADDR || data_req !== 1'b0 || memory_stall !== 1'b0) begin
            fails++;
            $display("FAIL %s back_to_idle: addr=%h req=%b stall=%b expected addr=%h req=0 stall=0",
                     tag, data_addr, data_req, memory_stall, RESET_ADDR);
        end
    endtask

    task automatic test_reset();
        mem_en = 1'b1; mem_addr = $urandom; mem_op = 3'd2;
        drive_edge();
        settle();
        tests++;
        if ({data_req, data_wr, data_size, data_wdata, load_result, access_done, memory_stall} !== '0 ||
            data_addr !== RESET_ADDR) begin
            fails++;
            $display("FAIL reset_values: req=%b wr=%b size=%0d addr=%h wdata=%h result=%h done=%b stall=%b",
                     data_req, data_wr, data_size, data_addr, data_wdata, load_result, access_done, memory_stall);
        end
        drive_edge();
        rst = 1'b0; mem_en = 1'b0;
    endtask

    task automatic test_word_load();
        do_access(1'b0, 3'd2, 32'h80001004, 32'd0, 32'hDEADBEEF, 1, 2, 3, "lw");
    endtask

    task automatic test_load_ext();
        do_access(1'b0, 3'b000, 32'h80002003, 32'd0, 32'h80FF1234, 0, 1, 0, "lb");
        do_access(1'b0, 3'b100, 32'h80002003, 32'd0, 32'h80FF1234, 1, 0, 0, "lbu");
        do_access(1'b0, 3'b001, 32'h80002002, 32'd0, 32'h80FF1234, 0, 2, 1, "lh");
        do_access(1'b0, 3'b101, 32'h80002002, 32'd0, 32'h80FF1234, 2, 1, 0, "lhu");
    endtask

    task automatic test_store_same_cycle();
        do_access(1'b1, 3'd0, 32'h80003001, 32'h123456A5, 32'hFFFFFFFF, 0, 0, 3, "sb");
    endtask

    task automatic test_flush_req();
        int done_seen;
        done_seen = 0;
        drive_edge();
        mem_en = 1'b1; mem_wr = 1'b0; mem_op = 3'd2; mem_addr = 32'h80004000;
        drive_edge();
        mem_flush = 1'b1; data_addr_ok = 1'b0;
        drive_edge();
        mem_flush = 1'b0; mem_en = 1'b0;
        settle();
        tests++;
        if (data_req !== 1'b0 || memory_stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_req: req=%b stall=%b expected req=0 stall=0", data_req, memory_stall);
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            settle();
            if (access_done !== 1'b0 || data_req !== 1'b0) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL flush_req_quiet: %0d cycles with done/req expected 0", done_seen);
        end
    endtask

    task automatic test_flush_wait();
        logic [31:0] prev;
        prev = $urandom;
        do_access(1'b0, 3'd2, 32'h80005000, 32'd0, prev, 0, 1, 0, "pre_flush");
        drive_edge();
        mem_en = 1'b1; mem_wr = 1'b0; mem_op = 3'd2; mem_addr = 32'h80005004;
        drive_edge();
        data_addr_ok = 1'b1;
        drive_edge();
        data_addr_ok = 1'b0; mem_flush = 1'b1;
        drive_edge();
        mem_flush = 1'b0; mem_en = 1'b0;
        settle();
        tests++;
        if (memory_stall !== 1'b1) begin
            fails++;
            $display("FAIL flush_wait_stall: stall=%b expected 1", memory_stall);
        end
        drive_edge();
        data_data_ok = 1'b1; data_rdata = ~prev;
        settle();
        tests++;
        if (memory_stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_wait_release: stall=%b expected 0", memory_stall);
        end
        drive_edge();
        data_data_ok = 1'b0;
        settle();
        tests++;
        if (access_done !== 1'b0 || load_result !== prev || data_req !== 1'b0) begin
            fails++;
            $display("FAIL flush_wait_discard: done=%b result=%h req=%b expected done=0 result=%h req=0",
                     access_done, load_result, data_req, prev);
        end
    endtask

    task automatic test_except();
        int bad;
        bad = 0;
        drive_edge();
        mem_en = 1'b1; mem_except = 1'b1; mem_addr = 32'h80006001; mem_op = 3'd2;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (data_req !== 1'b0 || memory_stall !== 1'b0) bad++;
            drive_edge();
        end
        mem_en = 1'b0; mem_except = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL except_no_req: %0d cycles with req/stall expected 0", bad);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] addr;
        logic        wr;
        for (int n = 0; n < 24; n++) begin
            op[1:0] = 2'($urandom_range(0, 2));
            op[2]   = 1'($urandom_range(0, 1));
            wr      = 1'($urandom_range(0, 1));
            addr    = $urandom & ~((32'd1 << op[1:0]) - 32'd1);
            do_access(wr, op, addr, $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_async_reset();
        drive_edge();
        mem_en = 1'b1; mem_wr = 1'b1; mem_op = 3'd1; mem_addr = 32'h80007002; mem_wdata = 32'h0000BEEF;
        drive_edge();
        data_addr_ok = 1'b1;
        drive_edge();
        data_addr_ok = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({data_req, data_wr, data_size, data_wdata, load_result, access_done, memory_stall} !== '0 ||
            data_addr !== RESET_ADDR) begin
            fails++;
            $display("FAIL async_reset: req=%b wr=%b size=%0d addr=%h wdata=%h result=%h done=%b stall=%b",
                     data_req, data_wr, data_size, data_addr, data_wdata, load_result, access_done, memory_stall);
        end
        drive_edge();
        rst = 1'b0; mem_en = 1'b0;
        drive_edge();
        settle();
        tests++;
        if (data_req !== 1'b0 || memory_stall !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: req=%b stall=%b expected 0 0", data_req, memory_stall);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_load_ext();
        test_store_same_cycle();
        test_flush_req();
        test_flush_wait();
        test_except();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
